// File: rtl/rv32im_dmem_ctrl.sv
// Data-memory controller: one decoded window, valid/ready request, one-cycle response strobe.
// Latency: response RD_LAT/WR_LAT edges after the accept edge; one request per LAT+2 cycles.
// Backpressure: req_ready only in IDLE, busy stalls the pipeline; DMEM_MISALIGN_CHK_EN adds be/addr checking.
module rv32im_dmem_ctrl #(
  parameter int unsigned SIZE_POW2 = 9,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned RD_LAT    = 2,
  parameter int unsigned WR_LAT    = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int unsigned WORDS  = 2 ** (SIZE_POW2 - 2);
  localparam logic [2:0]  RD_CNT = 3'(RD_LAT - 1);
  localparam logic [2:0]  WR_CNT = 3'(WR_LAT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic [31:0]          mem [WORDS];
  logic [SIZE_POW2-3:0] widx;
  logic                 hit;
  logic                 legal;
  logic                 access;
  logic                 do_write;

  assign widx     = addr_q[SIZE_POW2-1:2];
  assign hit      = (addr_q[31:SIZE_POW2] == BASE_ADDR[31:SIZE_POW2]);
  assign access   = (state_q == S_WAIT) && (cnt_q == 3'd0);
  assign do_write = access && we_q && hit && legal;

`ifdef DMEM_MISALIGN_CHK_EN
  // Byte enables must describe a naturally aligned byte, half-word or word.
  always_comb begin
    legal = 1'b0;
    case (be_q)
      4'b0000: legal = 1'b1;
      4'b0001: legal = (addr_q[1:0] == 2'd0);
      4'b0010: legal = (addr_q[1:0] == 2'd1);
      4'b0100: legal = (addr_q[1:0] == 2'd2);
      4'b1000: legal = (addr_q[1:0] == 2'd3);
      4'b0011: legal = (addr_q[1:0] == 2'd0);
      4'b1100: legal = (addr_q[1:0] == 2'd2);
      4'b1111: legal = (addr_q[1:0] == 2'd0);
      default: legal = 1'b0;
    endcase
  end
`else
  logic unused_addr_lo;
  assign legal          = 1'b1;
  assign unused_addr_lo = ^addr_q[1:0];
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          be_d    = req_be;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = req_we ? WR_CNT : RD_CNT;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q != 3'd0) begin
          cnt_d = cnt_q - 3'd1;
        end else begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_err_d   = !hit || !legal;
          // Writes leave the previous read data on the bus; misses and illegal reads return zero.
          if (!legal) begin
            rsp_rdata_d = '0;
          end else if (!we_q) begin
            rsp_rdata_d = hit ? mem[widx] : '0;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 3'd0;
      we_q        <= 1'b0;
      be_q        <= 4'd0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Array has no reset; a reset mid-operation forces IDLE so a pending write never commits.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (be_q[i]) mem[widx][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

  assign req_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_rv32im_dmem_ctrl.sv
// Bench for rv32im_dmem_ctrl: vector table plus reset/backpressure sequences, scoreboard-checked responses.
module tb_rv32im_dmem_ctrl;

  localparam int RD_LAT = 2;
  localparam int WR_LAT = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [3:0]  req_be;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  rv32im_dmem_ctrl #(
    .SIZE_POW2(9),
    .BASE_ADDR(32'h8000_0000),
    .RD_LAT   (RD_LAT),
    .WR_LAT   (WR_LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we   (req_we),
    .req_be   (req_be),
    .req_addr (req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err  (rsp_err),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  typedef struct {
    logic        err;
    logic [31:0] rdata;
    int          due;
    string       nm;
  } exp_t;

  vec_t tbl [14];
  exp_t sb [$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic push_exp(input logic e_err, input logic [31:0] e_rd, input int due, input string nm);
    exp_t e;
    e.err   = e_err;
    e.rdata = e_rd;
    e.due   = due;
    e.nm    = nm;
    sb.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (rsp_valid === 1'b1) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_rsp: rsp_valid=1 at cycle %0d with nothing outstanding", cyc);
        end else begin
          e = sb.pop_front();
          chk({e.nm, "_err"}, 32'(rsp_err), 32'(e.err));
          chk({e.nm, "_rdata"}, rsp_rdata, e.rdata);
          chk({e.nm, "_lat"}, 32'(cyc), 32'(e.due));
        end
      end
    end
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (req_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    if (req_ready !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL %s_ready: req_ready=%b after %0d cycles, required 1", nm, req_ready, n);
    end
  endtask

  task automatic drive_req(input logic we, input logic [3:0] be, input logic [31:0] addr,
                           input logic [31:0] wdata);
    req_valid = 1'b1;
    req_we    = we;
    req_be    = be;
    req_addr  = addr;
    req_wdata = wdata;
  endtask

  task automatic issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic e_err, input logic [31:0] e_rd,
                       input string nm);
    wait_ready(nm);
    drive_req(we, be, addr, wdata);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    push_exp(e_err, e_rd, cyc + (we ? WR_LAT : RD_LAT), nm);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || req_ready !== 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d responses still outstanding, required 0", sb.size());
    end
  endtask

  initial begin
    reset     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_be    = 4'h0;
    req_addr  = 32'h0;
    req_wdata = 32'h0;

    //          we    be       addr           wdata         err   rdata
    tbl[0]  = '{1'b1, 4'hF,    32'h8000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
    tbl[1]  = '{1'b0, 4'hF,    32'h8000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
    tbl[2]  = '{1'b1, 4'b0100, 32'h8000_0012, 32'h00AA_0000, 1'b0, 32'hDEAD_BEEF};
    tbl[3]  = '{1'b0, 4'hF,    32'h8000_0010, 32'h0,         1'b0, 32'hDEAA_BEEF};
    tbl[4]  = '{1'b0, 4'hF,    32'h8000_0200, 32'h0,         1'b1, 32'h0000_0000};
    tbl[5]  = '{1'b1, 4'hF,    32'h8000_0210, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
    tbl[6]  = '{1'b0, 4'hF,    32'h8000_0010, 32'h0,         1'b0, 32'hDEAA_BEEF};
    tbl[7]  = '{1'b1, 4'b0000, 32'h8000_0010, 32'h1111_1111, 1'b0, 32'hDEAA_BEEF};
    tbl[8]  = '{1'b0, 4'hF,    32'h8000_0010, 32'h0,         1'b0, 32'hDEAA_BEEF};
    tbl[9]  = '{1'b1, 4'hF,    32'h8000_01FC, 32'h5566_7788, 1'b0, 32'hDEAA_BEEF};
    tbl[10] = '{1'b0, 4'hF,    32'h8000_01FC, 32'h0,         1'b0, 32'h5566_7788};
    tbl[11] = '{1'b1, 4'b1000, 32'h8000_0013, 32'hCAFE_F00D, 1'b0, 32'h5566_7788};
    tbl[12] = '{1'b0, 4'hF,    32'h8000_0010, 32'h0,         1'b0, 32'hCAAA_BEEF};
    tbl[13] = '{1'b0, 4'hF,    32'h7FFF_FFFC, 32'h0,         1'b1, 32'h0000_0000};

    fork
      monitor();
    join_none

    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(req_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rdata", rsp_rdata, 32'h0);
    chk("rst_err", 32'(rsp_err), 32'd0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 14; i++) begin
      issue(tbl[i].we, tbl[i].be, tbl[i].addr, tbl[i].wdata, tbl[i].err, tbl[i].rdata,
            $sformatf("v%0d", i));
    end
    drain();

    // Reset during the WAIT of a read: no response, controller idle.
    wait_ready("s1");
    drive_req(1'b0, 4'hF, 32'h8000_0010, 32'h0);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    reset     = 1'b0;
    @(negedge clk);
    chk("s1_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("s1_busy", 32'(busy), 32'd0);
    chk("s1_rdata", rsp_rdata, 32'h0);
    reset = 1'b1;
    #1;
    chk("s1_ready", 32'(req_ready), 32'd1);
    @(negedge clk);

    // req_valid held through WAIT/RESP with a write attached must be ignored.
    wait_ready("s2");
    drive_req(1'b0, 4'hF, 32'h8000_0010, 32'h0);
    @(posedge clk);
    @(negedge clk);
    push_exp(1'b0, 32'hCAAA_BEEF, cyc + RD_LAT, "s2_rd");
    req_we    = 1'b1;
    req_wdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    chk("s2_not_accepted", 32'(busy), 32'd0);
    req_valid = 1'b0;
    issue(1'b0, 4'hF, 32'h8000_0010, 32'h0, 1'b0, 32'hCAAA_BEEF, "s2_chk");

    // Reset in the second WAIT cycle of a write drops the write.
    issue(1'b1, 4'hF, 32'h8000_0020, 32'hA5A5_A5A5, 1'b0, 32'hCAAA_BEEF, "s3_w0");
    wait_ready("s3");
    drive_req(1'b1, 4'hF, 32'h8000_0020, 32'h1234_5678);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("s3_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("s3_busy", 32'(busy), 32'd0);
    reset = 1'b1;
    #1;
    chk("s3_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    issue(1'b0, 4'hF, 32'h8000_0020, 32'h0, 1'b0, 32'hA5A5_A5A5, "s3_rd");

    // Half-word enables at an odd address.
    issue(1'b1, 4'hF, 32'h8000_0000, 32'h1122_3344, 1'b0, 32'hA5A5_A5A5, "s4_w0");
`ifdef DMEM_MISALIGN_CHK_EN
    issue(1'b1, 4'b0011, 32'h8000_0001, 32'h0000_BBCC, 1'b1, 32'h0000_0000, "s4_mis");
    issue(1'b0, 4'hF, 32'h8000_0000, 32'h0, 1'b0, 32'h1122_3344, "s4_rd");
`else
    issue(1'b1, 4'b0011, 32'h8000_0001, 32'h0000_BBCC, 1'b0, 32'hA5A5_A5A5, "s4_mis");
    issue(1'b0, 4'hF, 32'h8000_0000, 32'h0, 1'b0, 32'h1122_BBCC, "s4_rd");
`endif
    drain();
    repeat (5) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
